// File: rtl/ps2_host_tx_if.sv
// Command handshake and completion status between a host controller and ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (output tx_data, tx_valid, input tx_ready, done, err, err_code);
    modport slave  (input tx_data, tx_valid, output tx_ready, done, err, err_code);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out 8 data bits + odd parity
// + stop on device clock falls, then collect the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 7800,
    parameter int unsigned REQ_CYCLES     = 650,
    parameter int unsigned START_TIMEOUT  = 975000,
    parameter int unsigned XFER_TIMEOUT   = 130000,
    parameter int unsigned FILT_LEN       = 8
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave host,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    output logic         rx_inhibit
);
    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, WAITCLK, DATA, WAITIDLE, DONE, ERR
    } state_t;

    localparam int TW = 20;
    localparam logic [TW-1:0] T_MAX      = '1;
    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] REQ_LAST   = TW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);
    localparam logic [TW-1:0] GLITCH_WIN = TW'(FILT_LEN + 2);

    logic [1:0]          clk_s_q, data_s_q;
    logic [FILT_LEN-1:0] filt_q;
    logic                kclk_q, kclk_d;
    logic                fall, data_s;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [8:0]    frame_q, frame_d;
    logic          dbit_q, dbit_d;
    logic          ack_q, ack_d;
    logic [1:0]    err_code_q, err_code_d;

    logic clk_oe_c, data_oe_c, ready_c, done_c, err_c;

    // Synchronizers and filter idle high so reset never fabricates a clock fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s_q  <= '1;
            data_s_q <= '1;
            filt_q   <= '1;
            kclk_q   <= 1'b1;
        end else begin
            clk_s_q  <= {clk_s_q[0], ps2_clk_in};
            data_s_q <= {data_s_q[0], ps2_data_in};
            filt_q   <= {filt_q[FILT_LEN-2:0], clk_s_q[1]};
            kclk_q   <= kclk_d;
        end
    end

    always_comb begin
        kclk_d = kclk_q;
        if (&filt_q)
            kclk_d = 1'b1;
        else if (~|filt_q)
            kclk_d = 1'b0;
    end

    assign fall   = kclk_q & ~kclk_d;
    assign data_s = data_s_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            frame_q    <= '0;
            dbit_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitcnt_q   <= bitcnt_d;
            frame_q    <= frame_d;
            dbit_q     <= dbit_d;
            ack_q      <= ack_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;
        bitcnt_d   = bitcnt_q;
        frame_d    = frame_q;
        dbit_d     = dbit_q;
        ack_d      = ack_q;
        err_code_d = err_code_q;
        clk_oe_c   = 1'b0;
        data_oe_c  = 1'b0;
        ready_c    = 1'b0;
        done_c     = 1'b0;
        err_c      = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (host.tx_valid) begin
                    frame_d    = {~^host.tx_data, host.tx_data};
                    bitcnt_d   = '0;
                    err_code_d = 2'b00;
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_oe_c = 1'b1;
                if (timer_q == INH_LAST)
                    state_d = REQ;
            end
            REQ: begin
                clk_oe_c  = 1'b1;
                data_oe_c = 1'b1;
                if (timer_q == REQ_LAST)
                    state_d = WAITCLK;
            end
            WAITCLK: begin
                data_oe_c = 1'b1;
                if (timer_q == START_LAST) begin
                    err_code_d = 2'b10;
                    state_d    = ERR;
                end else if (fall && timer_q >= GLITCH_WIN) begin
                    // Ignoring early falls hides the filter catching up after our own clock release.
                    dbit_d   = frame_q[0];
                    bitcnt_d = 4'd1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                data_oe_c = ~dbit_q;
                if (timer_q == XFER_LAST) begin
                    err_code_d = 2'b11;
                    state_d    = ERR;
                end else if (fall) begin
                    if (bitcnt_q == 4'd10) begin
                        ack_d   = data_s;
                        state_d = WAITIDLE;
                    end else begin
                        dbit_d   = (bitcnt_q == 4'd9) ? 1'b1 : frame_q[bitcnt_q];
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            WAITIDLE: begin
                if (timer_q == XFER_LAST) begin
                    err_code_d = 2'b11;
                    state_d    = ERR;
                end else if (kclk_q && data_s) begin
                    if (ack_q) begin
                        err_code_d = 2'b01;
                        state_d    = ERR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The transfer timeout spans DATA and WAITIDLE, so that one transition keeps counting.
        if (state_d != state_q && !(state_q == DATA && state_d == WAITIDLE))
            timer_d = '0;
    end

    assign ps2_clk_oe    = clk_oe_c;
    assign ps2_data_oe   = data_oe_c;
    assign rx_inhibit    = (state_q != IDLE);
    assign host.tx_ready = ready_c;
    assign host.done     = done_c;
    assign host.err      = err_c;
    assign host.err_code = err_code_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model and a scoreboard of expected outcomes.
module tb_ps2_host_tx;
    localparam int P_INH  = 78;
    localparam int P_REQ  = 13;
    localparam int P_ST   = 2000;
    localparam int P_XF   = 1500;
    localparam int P_FL   = 8;
    localparam int HALF   = 20;
    localparam int LIM    = 6000;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk_oe, ps2_data_oe, rx_inhibit;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic clk_line, data_line;
    int   cyc = 0;
    int   n_pass = 0, n_chk = 0;
    int   bidx = 0;
    res_t exp_q[$];
    logic exp_bits[$];

    ps2_host_tx_if bus();

    assign clk_line  = dev_clk  & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(P_INH), .REQ_CYCLES(P_REQ), .START_TIMEOUT(P_ST),
        .XFER_TIMEOUT(P_XF), .FILT_LEN(P_FL)
    ) dut (
        .clk(clk), .reset(reset), .host(bus),
        .ps2_clk_in(clk_line), .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Outcome monitor: every done/err pulse is matched against the oldest expected outcome.
    always @(negedge clk) begin
        if (reset === 1'b1 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
            check("pulse_exclusive", int'(bus.done & bus.err), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'(bus.done) + 2 * int'(bus.err), 0);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                check("outcome_is_err", int'(bus.err), int'(r.is_err));
                check("outcome_code", int'(bus.err_code), int'(r.code));
            end
        end
    end

    // Bit monitor: the device model latches the line on each clock rise it generates.
    always @(posedge dev_clk) begin
        if (exp_bits.size() > 0) begin
            logic b;
            b = exp_bits.pop_front();
            check($sformatf("frame_bit%0d", bidx), int'(data_line), int'(b));
            bidx++;
        end
    end

    task automatic wait_ready(input string name);
        int i;
        i = 0;
        while (bus.tx_ready !== 1'b1 && i < LIM) begin
            @(negedge clk);
            i++;
        end
        check(name, int'(bus.tx_ready === 1'b1), 1);
    endtask

    task automatic send(input logic [7:0] d, input int nf, input bit ack_low,
                        input bit push_res, input res_t r, output int t_fall1);
        logic [8:0] fr;
        int n;
        fr = {~^d, d};
        t_fall1 = 0;
        @(negedge clk);
        check("ready_before_send", int'(bus.tx_ready), 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("accept_clk_oe", int'(ps2_clk_oe), 1);
        check("accept_ready_low", int'(bus.tx_ready), 0);
        check("accept_rx_inhibit", int'(rx_inhibit), 1);
        bidx = 0;
        for (int k = 1; k <= nf && k <= 10; k++)
            exp_bits.push_back((k <= 9) ? fr[k-1] : 1'b1);
        if (push_res) exp_q.push_back(r);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < LIM) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, P_INH);
        n = 0;
        while (ps2_clk_oe && ps2_data_oe && n < LIM) begin
            n++;
            @(negedge clk);
        end
        check("req_len", n, P_REQ);
        if (nf > 0) repeat (50) @(negedge clk);
        for (int k = 1; k <= nf; k++) begin
            @(negedge clk);
            dev_clk = 1'b0;
            if (k == 1) t_fall1 = cyc;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            #1;
            if (k == 10 && ack_low) dev_data = 1'b0;
            if (k == 11) dev_data = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int tf, n;
        res_t ok, e10, e11, e01;
        ok  = '{is_err: 1'b0, code: 2'b00};
        e10 = '{is_err: 1'b1, code: 2'b10};
        e11 = '{is_err: 1'b1, code: 2'b11};
        e01 = '{is_err: 1'b1, code: 2'b01};
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", int'(bus.tx_ready), 1);
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_data_oe", int'(ps2_data_oe), 0);
        check("rst_rx_inhibit", int'(rx_inhibit), 0);
        check("rst_done_err", int'(bus.done) + int'(bus.err), 0);
        check("rst_err_code", int'(bus.err_code), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1 then parity 1, stop 1, ACK low
        send(8'hED, 11, 1'b1, 1'b1, ok, tf);
        wait_ready("ed_ready_back");
        check("ed_err_code", int'(bus.err_code), 0);

        send(8'hFF, 11, 1'b1, 1'b1, ok, tf);
        wait_ready("ff_ready_back");

        // 0x01 has one set bit, so its parity bit is 0
        send(8'h01, 11, 1'b1, 1'b1, ok, tf);
        wait_ready("01_ready_back");

        // Device never clocks: err exactly START cycles after the clock line is released
        send(8'hF0, 0, 1'b0, 1'b1, e10, tf);
        n = 0;
        while (bus.err !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("start_timeout_len", n, P_ST);
        check("start_timeout_oe", int'(ps2_clk_oe) + int'(ps2_data_oe), 0);
        wait_ready("st_ready_back");
        check("st_err_code_hold", int'(bus.err_code), 2);

        // Device stops after fall 5: transfer timeout measured from the first pin fall
        send(8'h3C, 5, 1'b0, 1'b1, e11, tf);
        n = 0;
        while (bus.err !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("xfer_timeout_window", int'((cyc - tf) >= P_XF && (cyc - tf) <= P_XF + P_FL + 4), 1);
        wait_ready("xf_ready_back");
        check("xf_err_code_hold", int'(bus.err_code), 3);

        // Device leaves data high at fall 11: no-ACK error
        send(8'hA5, 11, 1'b0, 1'b1, e01, tf);
        wait_ready("na_ready_back");
        check("na_err_code_hold", int'(bus.err_code), 1);

        // Reset mid-frame after four falls (bitcnt=4)
        send(8'h5A, 4, 1'b0, 1'b0, ok, tf);
        check("mid_frame_busy", int'(rx_inhibit), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_oe", int'(ps2_clk_oe) + int'(ps2_data_oe), 0);
        check("mid_rst_ready", int'(bus.tx_ready), 1);
        check("mid_rst_err_code", int'(bus.err_code), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h00, 11, 1'b1, 1'b1, ok, tf);
        wait_ready("00_ready_back");
        repeat (5) @(negedge clk);

        check("outcomes_drained", exp_q.size(), 0);
        check("bits_drained", exp_bits.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
